// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared channel indices, debounce FSM encoding and cycle-count helper.
package input_cond_pkg;

    localparam int CH_HOOKED   = 0;
    localparam int CH_UNHOOKED = 1;
    localparam int CH_WRITE    = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    function automatic int ms_to_cyc(input int hz, input int ms);
        return hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce FSM and pulse generation for one input bit.
// Long-press hold counter is built only when INPUT_COND_LONG_PRESS_EN is defined.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DB_CYC   = 4
`ifdef INPUT_COND_LONG_PRESS_EN
   ,parameter int LONG_CYC = 20
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CLAST = CW'(DB_CYC - 1);

    logic [1:0]    sync_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q, press_q, release_q;
    logic          sync;

    assign sync = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: if (sync) begin
                    state_q <= PRESS_WAIT;
                    cnt_q   <= '0;
                end
                PRESS_WAIT: if (!sync) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == CLAST) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                    press_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                HELD: if (!sync) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= '0;
                end
                RELEASE_WAIT: if (sync) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                end else if (cnt_q == CLAST) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    release_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef INPUT_COND_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYC);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q;

    always_comb hold_d = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;

    // Counts from the first HELD cycle and saturates, so the pulse never repeats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
            hold_q <= hold_d;
            long_q <= (hold_q != HMAX) && (hold_d == HMAX);
        end else begin
            hold_q <= '0;
            long_q <= 1'b0;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces the three button inputs and tracks hook state.
// Optional long-press pulses are enabled with INPUT_COND_LONG_PRESS_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic [2:0] btn_release,
    output logic [2:0] btn_long,
    output logic       hook_state
);

    localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);

    if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_cfg_err
        $error("input_conditioner: need DB_CYC >= 1 and LONG_CYC > DB_CYC");
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        debounce_channel #(
            .DB_CYC  (DB_CYC)
`ifdef INPUT_COND_LONG_PRESS_EN
           ,.LONG_CYC(LONG_CYC)
`endif
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .long_o   (btn_long[i])
        );
    end

    logic hook_q, hook_d;

    // Conflicting presses in one cycle leave the state alone.
    always_comb hook_d = (btn_press[CH_UNHOOKED] && !btn_press[CH_HOOKED]) ? 1'b1 :
                         (btn_press[CH_HOOKED] && !btn_press[CH_UNHOOKED]) ? 1'b0 : hook_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hook_q <= 1'b0;
        else       hook_q <= hook_d;
    end

    assign hook_state = hook_q;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioner for the phone-control core. Takes the three asynchronous push-button/switch inputs (handset hooked, handset unhooked, write-mode request) and turns them into clean signals for the core: synchronised and debounced levels, single-cycle press/release pulses, optional long-press pulses, and a registered hook state. Sits directly upstream of `main`, which consumes `btn_press` and `hook_state` in place of the raw pins.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `DEBOUNCE_MS`, 20, stability window. `DB_CYC = CLK_HZ/1000*DEBOUNCE_MS`; must be ≥ 1.
- `LONG_MS`, 1000, long-press threshold. `LONG_CYC = CLK_HZ/1000*LONG_MS`; must be > `DB_CYC`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_raw`  in  3  raw inputs, asynchronous to `clk`. Bit 0 = hooked, bit 1 = unhooked, bit 2 = write_mode.
- `btn_level`  out  3  debounced levels.
- `btn_press`  out  3  one-cycle pulse on a debounced 0→1 transition.
- `btn_release`  out  3  one-cycle pulse on a debounced 1→0 transition.
- `btn_long`  out  3  one-cycle pulse at the long-press threshold. Tied to 0 when the feature is disabled (see Configuration).
- `hook_state`  out  1  1 = off-hook (unhooked), 0 = on-hook.

## Operation
- Channel path: each bit passes through a 2-flop synchroniser, producing `sync`.
- Per-channel state machine:
  - States: IDLE (level 0), PRESS_WAIT (level 0, counting), HELD (level 1), RELEASE_WAIT (level 1, counting).
  - IDLE→PRESS_WAIT when `sync`=1.
  - PRESS_WAIT→IDLE when `sync`=0; the counter clears.
  - PRESS_WAIT→HELD after `DB_CYC` consecutive cycles with `sync`=1.
  - HELD/RELEASE_WAIT behave symmetrically for the 1→0 direction.
- Debounce counter:
  - Width `$clog2(DB_CYC+1)`.
  - Clears on every state change and on every glitch back to the current level.
  - Never wraps.
- Pulses: `btn_press` is asserted exactly in the first cycle in which `btn_level` reads 1; `btn_release` likewise when it first reads 0. Never more than one cycle wide.
- Hook state:
  - Set to 1 on `btn_press[1]`; set to 0 on `btn_press[0]`.
  - Both presses in the same cycle: `hook_state` is held unchanged.
  - A press that matches the current state causes no change.
- `btn_level[2]` (write_mode) is passed through to the core; the core owns its mode semantics.
- Reset (asserted at any time, including mid-count):
  - All outputs go to 0 immediately.
  - FSMs go to IDLE; counters and synchronisers clear.
  - If an input is held high through reset release, it must complete a full `DB_CYC` window before `btn_press` fires.

## Timing
- Press latency: from raw edge to `btn_level`/`btn_press` is 2 (synchroniser) + `DB_CYC` cycles, ±1 cycle of synchroniser uncertainty. Release latency is identical.
- `hook_state` updates on the cycle after `btn_press`.
- `btn_long` fires `LONG_CYC` cycles after `btn_level` rises, if the level is still 1.
- Glitches of length < `DB_CYC` cycles produce no output change.

## Configuration
- Macro: `INPUT_COND_LONG_PRESS_EN`.
- Defined:
  - Per-channel hold counter, width `$clog2(LONG_CYC+1)`, increments while in HELD/RELEASE_WAIT.
  - At `LONG_CYC` it emits a single `btn_long` pulse, then saturates (no auto-repeat).
  - Clears on entry to IDLE.
- Undefined: no hold counters are synthesised and `btn_long` is constant 3'b000.

## Structure
- Package `input_cond_pkg` contains:
  - Channel index constants `CH_HOOKED=0`, `CH_UNHOOKED=1`, `CH_WRITE=2`.
  - The 2-bit FSM state encoding.
  - The function computing cycle counts from Hz/ms.
- Sub-module `debounce_channel`: synchroniser + FSM + counters for one bit. It is instantiated three times by `input_conditioner`, which adds only the hook-state logic.

## Test plan
All tests use `CLK_HZ`=1000 (so `DB_CYC`=`DEBOUNCE_MS`, `LONG_CYC`=`LONG_MS`), `DEBOUNCE_MS`=4, `LONG_MS`=20.
- Clean press: `btn_raw[1]` driven 0→1 and held → `btn_press[1]` is a single pulse 6±1 cycles later, and `hook_state`=1 one cycle after that.
- Bounce: `btn_raw[0]` toggles 1,0,1,0 at 2-cycle spacing, then stays high → no pulse during the bounce; exactly one `btn_press[0]` 6±1 cycles after the final rise.
- Long press (macro defined): `btn_raw[2]` held for 30 cycles → `btn_press[2]`, then exactly one `btn_long[2]` 20 cycles later, then `btn_release[2]` after release. With the macro undefined → `btn_long` stays 0.
- Simultaneous: `btn_raw[0]` and `btn_raw[1]` rise on the same edge while `hook_state`=1 → both press pulses appear and `hook_state` remains 1.
- Reset mid-count: `reset` asserted 2 cycles into PRESS_WAIT → all outputs 0 at once. With the input still high at reset release, `btn_press` fires 6±1 cycles after release.
- Short glitch: a 3-cycle high pulse on any channel → no change on `btn_level`, `btn_press` or `btn_release`.
